timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 134 +++++++++++++
 tb/tb_timer_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// MM:SS timer controller: prescales clk into count ticks, sequences load/clear
// strobes to an external BCD counter datapath and flags countdown expiry.
module timer_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        mode,
    input  logic [15:0] count,
    output logic        tick,
    output logic        cnt_mode,
    output logic        ld,
    output logic [15:0] ld_val,
    output logic        running,
    output logic        alarm,
    output logic        err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    state_t        stateReg;
    state_t        nextState;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescalerNext;
    logic          tickNext;
    logic          ldNext;
    logic [15:0]   ldValNext;
    logic          errNext;
    logic          cntModeNext;
    logic          presetValid;

    assign presetValid = (preset[15:12] <= 4'd5) && (preset[11:8] <= 4'd9) &&
                         (preset[7:4]   <= 4'd5) && (preset[3:0]  <= 4'd9);

    assign state = stateReg;

    // Requests are resolved strictly as clear > load > stop > start; a load in
    // RUN is treated as absent so the lower-priority requests still apply.
    always_comb begin
        nextState     = stateReg;
        prescalerNext = prescaler;
        tickNext      = 1'b0;
        ldNext        = 1'b0;
        ldValNext     = ld_val;
        errNext       = 1'b0;
        cntModeNext   = cnt_mode;

        if (clear) begin
            nextState     = IDLE;
            prescalerNext = '0;
            ldNext        = 1'b1;
            ldValNext     = 16'h0000;
        end else if (load && (stateReg != RUN)) begin
            if (presetValid) begin
                nextState     = IDLE;
                prescalerNext = '0;
                ldNext        = 1'b1;
                ldValNext     = preset;
            end else begin
                errNext = 1'b1;
            end
        end else begin
            case (stateReg)
                RUN: begin
                    if (cnt_mode && (count == 16'h0000)) begin
                        nextState     = EXPIRED;
                        prescalerNext = '0;
                    end else if (stop) begin
                        nextState = PAUSE;
                    end else if (prescaler == LAST) begin
                        prescalerNext = '0;
                        tickNext      = 1'b1;
                    end else begin
                        prescalerNext = prescaler + PW'(1);
                    end
                end
                IDLE: begin
                    if (start && !stop) begin
                        nextState     = RUN;
                        prescalerNext = '0;
                        cntModeNext   = mode;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        nextState = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags are derived from the next state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg  <= IDLE;
            prescaler <= '0;
            tick      <= 1'b0;
            ld        <= 1'b0;
            ld_val    <= 16'h0000;
            err       <= 1'b0;
            cnt_mode  <= 1'b0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            stateReg  <= nextState;
            prescaler <= prescalerNext;
            tick      <= tickNext;
            ld        <= ldNext;
            ld_val    <= ldValNext;
            err       <= errNext;
            cnt_mode  <= cntModeNext;
            running   <= (nextState == RUN);
            alarm     <= (nextState == EXPIRED);
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl with TICK_DIV = 4; each task checks one
// feature against hand-computed cycle positions and values.
module tb_timer_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic        load;
    logic [15:0] preset;
    logic        mode;
    logic [15:0] count;
    logic        tick;
    logic        cnt_mode;
    logic        ld;
    logic [15:0] ld_val;
    logic        running;
    logic        alarm;
    logic        err;
    logic [1:0]  state;

    int compared;
    int mismatched;

    timer_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load(load), .preset(preset), .mode(mode), .count(count),
        .tick(tick), .cnt_mode(cnt_mode), .ld(ld), .ld_val(ld_val),
        .running(running), .alarm(alarm), .err(err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if ({state, tick, ld, err, running, alarm, cnt_mode} !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got state=%b tick=%b ld=%b err=%b run=%b alarm=%b mode=%b, expected all 0",
                     state, tick, ld, err, running, alarm, cnt_mode);
        end
        compared++;
        if (ld_val !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_ld_val: got %h expected 0000", ld_val);
        end
        rst = 1'b0;
        step();
        compared++;
        if (state !== 2'b00 || running !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL first_edge_idle: got state=%b running=%b expected 00/0", state, running);
        end
    endtask

    task automatic test_countdown();
        int   ticks;
        int   lastTick;
        int   expireAt;
        logic tickPrev;
        preset = 16'h0003; mode = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        compared++;
        if (ld !== 1'b1 || ld_val !== 16'h0003 || state !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL load_strobe: got ld=%b ld_val=%h state=%b expected 1/0003/00", ld, ld_val, state);
        end
        step();
        compared++;
        if (ld !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_one_cycle: got ld=%b expected 0", ld);
        end
        count = 16'h0003; start = 1'b1;
        step();
        start = 1'b0;
        compared++;
        if (state !== 2'b01 || running !== 1'b1 || cnt_mode !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL countdown_start: got state=%b running=%b cnt_mode=%b expected 01/1/1", state, running, cnt_mode);
        end
        ticks = 0; lastTick = 0; expireAt = 0; tickPrev = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (tickPrev) count = count - 16'd1;
            tickPrev = tick;
            if (tick === 1'b1) begin
                ticks++;
                compared++;
                if (i != lastTick + 4) begin
                    mismatched++;
                    $display("[TB] FAIL tick_period: got tick at cycle %0d expected %0d", i, lastTick + 4);
                end
                lastTick = i;
            end
            if (state === 2'b11 && expireAt == 0) expireAt = i;
        end
        compared++;
        if (ticks != 3) begin
            mismatched++;
            $display("[TB] FAIL countdown_ticks: got %0d expected 3", ticks);
        end
        compared++;
        if (expireAt != 14 || alarm !== 1'b1 || running !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL expire: got cycle=%0d alarm=%b running=%b expected 14/1/0", expireAt, alarm, running);
        end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        compared++;
        if (state !== 2'b11 || alarm !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL expired_sticky: got state=%b alarm=%b expected 11/1", state, alarm);
        end
    endtask

    task automatic test_count_up();
        int ticks;
        clear = 1'b1;
        step();
        clear = 1'b0;
        compared++;
        if (state !== 2'b00 || ld !== 1'b1 || ld_val !== 16'h0000 || alarm !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_expired: got state=%b ld=%b ld_val=%h alarm=%b expected 00/1/0000/0", state, ld, ld_val, alarm);
        end
        mode = 1'b0; count = 16'h5959; start = 1'b1;
        step();
        start = 1'b0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        compared++;
        if (ticks != 2 || state !== 2'b01 || alarm !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL count_up_5959: got ticks=%0d state=%b alarm=%b expected 2/01/0", ticks, state, alarm);
        end
        count = 16'h0000;
        for (int i = 0; i < 4; i++) step();
        compared++;
        if (state !== 2'b01 || alarm !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL count_up_no_expire: got state=%b alarm=%b expected 01/0", state, alarm);
        end
    endtask

    task automatic test_pause_resume();
        int found;
        int ticks;
        int first;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            step();
            if (tick === 1'b1) found = 1;
        end
        compared++;
        if (found == 0) begin
            mismatched++;
            $display("[TB] FAIL sync_tick: got no tick within 8 cycles expected one");
        end
        ticks = 0;
        step();
        if (tick === 1'b1) ticks++;
        step();
        if (tick === 1'b1) ticks++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        if (tick === 1'b1) ticks++;
        compared++;
        if (state !== 2'b10 || running !== 1'b0 || ticks != 0) begin
            mismatched++;
            $display("[TB] FAIL pause_enter: got state=%b running=%b ticks=%0d expected 10/0/0", state, running, ticks);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        compared++;
        if (ticks != 0 || state !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL paused_quiet: got ticks=%0d state=%b expected 0/10", ticks, state);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        compared++;
        if (state !== 2'b01 || cnt_mode !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL resume: got state=%b cnt_mode=%b expected 01/0", state, cnt_mode);
        end
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (tick === 1'b1 && first == 0) first = i;
        end
        compared++;
        if (first != 2) begin
            mismatched++;
            $display("[TB] FAIL resume_phase: got first tick at %0d expected 2", first);
        end
    endtask

    task automatic test_bad_preset();
        stop = 1'b1;
        step();
        stop = 1'b0;
        preset = 16'h6000; load = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        compared++;
        if (err !== 1'b1 || ld !== 1'b0 || state !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL bad_preset_6000: got err=%b ld=%b state=%b expected 1/0/10", err, ld, state);
        end
        step();
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_one_cycle: got err=%b expected 0", err);
        end
        preset = 16'h000A; load = 1'b1;
        step();
        load = 1'b0;
        compared++;
        if (err !== 1'b1 || ld !== 1'b0 || state !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL bad_preset_000A: got err=%b ld=%b state=%b expected 1/0/10", err, ld, state);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        start = 1'b0;
        preset = 16'h0100; load = 1'b1;
        step();
        load = 1'b0;
        compared++;
        if (ld !== 1'b0 || state !== 2'b01 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL load_in_run: got ld=%b state=%b err=%b expected 0/01/0", ld, state, err);
        end
        preset = 16'h1234; clear = 1'b1; load = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; load = 1'b0; start = 1'b0;
        compared++;
        if (state !== 2'b00 || ld !== 1'b1 || ld_val !== 16'h0000 || tick !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_priority: got state=%b ld=%b ld_val=%h tick=%b expected 00/1/0000/0", state, ld, ld_val, tick);
        end
    endtask

    task automatic test_reset_mid_run();
        int first;
        preset = 16'h1234; mode = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        compared++;
        if (ld_val !== 16'h1234) begin
            mismatched++;
            $display("[TB] FAIL load_1234: got ld_val=%h expected 1234", ld_val);
        end
        count = 16'h1234; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        compared++;
        if (running !== 1'b1 || cnt_mode !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL run_before_rst: got running=%b cnt_mode=%b expected 1/1", running, cnt_mode);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({state, tick, ld, err, running, alarm, cnt_mode} !== 8'h00 || ld_val !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got state=%b run=%b mode=%b ld_val=%h expected 00/0/0/0000", state, running, cnt_mode, ld_val);
        end
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick === 1'b1 && first == 0) first = i;
        end
        compared++;
        if (first != 4) begin
            mismatched++;
            $display("[TB] FAIL restart_phase: got first tick at %0d expected 4", first);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        preset = 16'h0000; mode = 1'b0; count = 16'h0000;
        $display("[TB] timer_ctrl directed test start");
        test_reset();
        test_countdown();
        test_count_up();
        test_pause_resume();
        test_bad_preset();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
